multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter IW, default 9: instruction width in bits; legal range 9..16.
REQ-002 Parameter OPW, default 4: opcode width, taken from Instruction[IW-1 -: OPW]; OPW SHALL be less than IW.
REQ-003 CLK  input  1: single clock; all state changes on the rising edge.
REQ-004 reset_n  input  1: asynchronous, active-low reset.
REQ-005 instr_valid  input  1: fetch unit presents a valid instruction.
REQ-006 Instruction  input  IW: instruction word.
REQ-007 instr_ready  output  1: controller accepts an instruction this cycle.
REQ-008 mem_ready  input  1: data memory has completed the current access.
REQ-009 resume  input  1: leave the halted state.
REQ-010 Format, AccRead, Branch, MemWrite, PCWrite  output  1 each: datapath controls.
REQ-011 RegWrite, ALUSrcB, MemtoReg  output  2 each; ALUOp  output  4: datapath controls.
REQ-012 HALT  output  1: processor halted; state  output  3: current FSM state.

Function
REQ-013 The FSM SHALL have states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALTED=5; codes 6 and 7 SHALL go to FETCH on the next edge.
REQ-014 FETCH: instr_ready=1; on instr_valid&&instr_ready latch Instruction -> DECODE; otherwise stay.
REQ-015 DECODE: latch the decoded control word from the package opcode table -> EXEC, or -> HALTED when opcode is all-ones.
REQ-016 EXEC: ALUOp/ALUSrcB/Format/AccRead driven from the control word; Branch=1 for branch opcodes; then -> MEM if load/store, -> WB if RegWrite!=0, else -> FETCH.
REQ-017 MEM: MemWrite=1 every cycle for store; stay while mem_ready=0; on mem_ready=1: load -> WB, store -> FETCH.
REQ-018 WB: RegWrite and MemtoReg driven for exactly one cycle -> FETCH.
REQ-019 PCWrite SHALL pulse for exactly one cycle, in the last cycle of every non-halt instruction (retire).
REQ-020 Outside its owning state, each strobe (Branch, MemWrite, RegWrite, PCWrite) SHALL be 0; instr_ready SHALL be 0 outside FETCH.
REQ-021 HALTED: HALT=1 and all strobes 0; resume=1 -> FETCH next cycle; instr_valid ignored.
REQ-022 Latency (handshake to next instr_ready): ALU op 4 cycles, store 4+N, load 5+N, where N is the number of mem_ready-low cycles.
REQ-023 mem_ready asserted outside MEM SHALL be ignored.

Reset
REQ-024 With reset_n=0 (asynchronous, mid-operation included), state=FETCH, the latched instruction and control word are 0, and every output is 0 except instr_ready, which is 1 once reset_n=1.

Configuration
REQ-025 Macro MC_PERF_CNT_EN defined: add outputs retire_cnt[31:0] (+1 per PCWrite) and stall_cnt[31:0] (+1 per MEM cycle with mem_ready=0).
REQ-026 Both counters SHALL wrap modulo 2^32 and reset to 0.
REQ-027 Macro MC_PERF_CNT_EN undefined: the counters and their ports are absent.

Structure
REQ-028 The shared package SHALL hold:
- the state enum;
- the opcode enum: ADD..SHR 0-6, ADDI 7, LD 8, ST 9, BEQ A, BNE B, MOVA C, MOVR D, JMP E, HALT F;
- the ALUOp encodings;
- the packed control-word struct.
REQ-029 The combinational decoder SHALL be the sub-module mc_decode: opcode in, control-word struct out.

Verification
REQ-030 ADD (opcode 0), mem_ready don't-care:
- states FETCH, DECODE, EXEC, WB, FETCH;
- RegWrite!=0 only in WB;
- PCWrite pulses in WB.
REQ-031 ST (opcode 9), mem_ready low 3 cycles:
- MemWrite=1 for 4 cycles;
- next instr_ready 7 cycles after the handshake;
- stall_cnt=3 when MC_PERF_CNT_EN is defined.
REQ-032 LD (opcode 8), mem_ready=1 immediately:
- MEM, then WB with MemtoReg!=0;
- 5-cycle latency.
REQ-033 HALT (opcode F):
- HALT=1 from the cycle after DECODE;
- instr_valid pulses ignored;
- resume=1 -> FETCH with HALT=0.
REQ-034 reset_n low asynchronously during MEM:
- all outputs 0 with no clock edge;
- after release, state=FETCH and instr_ready=1.
REQ-035 With MC_PERF_CNT_EN: 10 retired ALU ops -> retire_cnt=10; preload 0xFFFFFFFF, one more retire -> 0.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle accumulator-machine controller.
// Holds the FSM state encoding, the opcode map, the ALUOp / ALUSrcB /
// RegWrite / MemtoReg encodings, the packed control word produced by the
// decoder, and a helper that tells whether an instruction retires in EXEC.
package multicycle_control_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALTED = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_XOR  = 4'h4,
    OP_SHL  = 4'h5,
    OP_SHR  = 4'h6,
    OP_ADDI = 4'h7,
    OP_LD   = 4'h8,
    OP_ST   = 4'h9,
    OP_BEQ  = 4'hA,
    OP_BNE  = 4'hB,
    OP_MOVA = 4'hC,
    OP_MOVR = 4'hD,
    OP_JMP  = 4'hE,
    OP_HALT = 4'hF
  } opcode_e;

  // ALU operation select
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SHL  = 4'd5;
  localparam logic [3:0] ALU_SHR  = 4'd6;
  localparam logic [3:0] ALU_PASS = 4'd7;

  // ALU B-operand source
  localparam logic [1:0] SRCB_REG = 2'd0;
  localparam logic [1:0] SRCB_IMM = 2'd1;
  localparam logic [1:0] SRCB_JMP = 2'd2;

  // Register-file write target
  localparam logic [1:0] RW_NONE = 2'd0;
  localparam logic [1:0] RW_REG  = 2'd1;
  localparam logic [1:0] RW_ACC  = 2'd2;

  // Write-back data source
  localparam logic [1:0] M2R_ALU = 2'd0;
  localparam logic [1:0] M2R_MEM = 2'd1;

  typedef struct packed {
    logic [3:0] alu_op;
    logic [1:0] alu_src_b;
    logic [1:0] reg_write;
    logic [1:0] mem_to_reg;
    logic       format;
    logic       acc_read;
    logic       branch;
    logic       load;
    logic       store;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = ctrl_t'(15'd0);

  // An instruction with no memory access and no write-back finishes in EXEC.
  function automatic logic retires_in_exec(input ctrl_t c);
    return !c.load && !c.store && (c.reg_write == RW_NONE);
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode decoder.
// Ports: opcode (4-bit opcode) in, ctrl (packed control word) out.
// HALT and any unlisted code decode to the all-zero control word.
module mc_decode
  import multicycle_control_pkg::*;
(
  input  logic [3:0] opcode,
  output ctrl_t      ctrl
);

  // Opcode table lookup
  always_comb begin
    ctrl = CTRL_NOP;
    case (opcode)
      OP_ADD:  begin ctrl.alu_op = ALU_ADD; ctrl.reg_write = RW_REG; end
      OP_SUB:  begin ctrl.alu_op = ALU_SUB; ctrl.reg_write = RW_REG; end
      OP_AND:  begin ctrl.alu_op = ALU_AND; ctrl.reg_write = RW_REG; end
      OP_OR:   begin ctrl.alu_op = ALU_OR;  ctrl.reg_write = RW_REG; end
      OP_XOR:  begin ctrl.alu_op = ALU_XOR; ctrl.reg_write = RW_REG; end
      OP_SHL:  begin ctrl.alu_op = ALU_SHL; ctrl.reg_write = RW_REG; end
      OP_SHR:  begin ctrl.alu_op = ALU_SHR; ctrl.reg_write = RW_REG; end
      OP_ADDI: begin
        ctrl.alu_op = ALU_ADD; ctrl.alu_src_b = SRCB_IMM; ctrl.format = 1'b1;
        ctrl.reg_write = RW_REG;
      end
      OP_LD: begin
        ctrl.alu_op = ALU_ADD; ctrl.alu_src_b = SRCB_IMM; ctrl.format = 1'b1;
        ctrl.load = 1'b1; ctrl.reg_write = RW_REG; ctrl.mem_to_reg = M2R_MEM;
      end
      OP_ST: begin
        ctrl.alu_op = ALU_ADD; ctrl.alu_src_b = SRCB_IMM; ctrl.format = 1'b1;
        ctrl.acc_read = 1'b1; ctrl.store = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        ctrl.alu_op = ALU_SUB; ctrl.alu_src_b = SRCB_REG; ctrl.format = 1'b1;
        ctrl.acc_read = 1'b1; ctrl.branch = 1'b1;
      end
      OP_MOVA: begin ctrl.alu_op = ALU_PASS; ctrl.reg_write = RW_ACC; end
      OP_MOVR: begin ctrl.alu_op = ALU_PASS; ctrl.acc_read = 1'b1; ctrl.reg_write = RW_REG; end
      OP_JMP: begin
        ctrl.alu_op = ALU_PASS; ctrl.alu_src_b = SRCB_JMP; ctrl.format = 1'b1;
        ctrl.branch = 1'b1;
      end
      OP_HALT: ctrl = CTRL_NOP;
      default: ctrl = CTRL_NOP;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle controller: FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH,
// plus a HALTED state left by 'resume'.
// Parameters: IW instruction width (9..16), OPW opcode width (< IW), opcode
// taken from Instruction[IW-1 -: OPW].
// Inputs : CLK, reset_n (async, active low), instr_valid, Instruction,
//          mem_ready, resume.
// Outputs: instr_ready, Format, AccRead, Branch, MemWrite, PCWrite,
//          RegWrite[1:0], ALUSrcB[1:0], MemtoReg[1:0], ALUOp[3:0], HALT,
//          state[2:0].
// Optional: macro MC_PERF_CNT_EN adds retire_cnt[31:0] and stall_cnt[31:0].
// Datapath controls are registered from the next-state value so they line up
// with the state they belong to. Two terms are deliberately not pure flops:
// instr_ready is gated by reset_n so it drops during reset and rises as soon
// as reset is released, and a store retires in the MEM cycle where mem_ready
// is seen, which is only known combinationally.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int IW  = 9,
  parameter int OPW = 4
) (
  input  logic          CLK,
  input  logic          reset_n,
  input  logic          instr_valid,
  input  logic [IW-1:0] Instruction,
  output logic          instr_ready,
  input  logic          mem_ready,
  input  logic          resume,
  output logic          Format,
  output logic          AccRead,
  output logic          Branch,
  output logic          MemWrite,
  output logic          PCWrite,
  output logic [1:0]    RegWrite,
  output logic [1:0]    ALUSrcB,
  output logic [1:0]    MemtoReg,
  output logic [3:0]    ALUOp,
  output logic          HALT,
  output logic [2:0]    state
`ifdef MC_PERF_CNT_EN
  ,
  output logic [31:0]   retire_cnt,
  output logic [31:0]   stall_cnt
`endif
);

  state_e          state_q, state_d;
  logic [IW-1:0]   instr_q, instr_d;
  ctrl_t           ctrl_q, ctrl_d, dec_ctrl_s;
  logic [OPW-1:0]  op_s;
  logic            op_halt_s;
  logic            instr_unused_s;
  logic            exec_s, wb_s, store_retire_s, pc_write_s;

  logic            instr_ready_q, instr_ready_d;
  logic            format_q, format_d, acc_read_q, acc_read_d;
  logic            branch_q, branch_d, mem_write_q, mem_write_d;
  logic            pc_write_q, pc_write_d, halt_q, halt_d;
  logic [1:0]      reg_write_q, reg_write_d, alu_src_b_q, alu_src_b_d;
  logic [1:0]      mem_to_reg_q, mem_to_reg_d;
  logic [3:0]      alu_op_q, alu_op_d;

  assign op_s           = instr_q[IW-1 -: OPW];
  assign op_halt_s      = &op_s;
  // Operand field is for the datapath; the controller only looks at the opcode.
  assign instr_unused_s = ^instr_q[IW-OPW-1:0];

  mc_decode u_decode (
    .opcode (4'(op_s)),
    .ctrl   (dec_ctrl_s)
  );

  // Next-state, instruction latch and control-word latch
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    ctrl_d  = ctrl_q;
    case (state_q)
      S_FETCH: begin
        if (instr_valid) begin
          instr_d = Instruction;
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        ctrl_d = dec_ctrl_s;
        if (op_halt_s) begin
          state_d = S_HALTED;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (ctrl_q.load || ctrl_q.store) begin
          state_d = S_MEM;
        end else if (ctrl_q.reg_write != RW_NONE) begin
          state_d = S_WB;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        if (!mem_ready) begin
          state_d = S_MEM;
        end else if (ctrl_q.load) begin
          state_d = S_WB;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_WB:     state_d = S_FETCH;
      S_HALTED: begin
        if (resume) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_HALTED;
        end
      end
      default:  state_d = S_FETCH;
    endcase
  end

  // Output values for the state being entered
  always_comb begin
    exec_s        = (state_d == S_EXEC);
    wb_s          = (state_d == S_WB);
    instr_ready_d = (state_d == S_FETCH);
    halt_d        = (state_d == S_HALTED);
    alu_op_d      = exec_s ? ctrl_d.alu_op    : 4'd0;
    alu_src_b_d   = exec_s ? ctrl_d.alu_src_b : 2'd0;
    format_d      = exec_s & ctrl_d.format;
    acc_read_d    = exec_s & ctrl_d.acc_read;
    branch_d      = exec_s & ctrl_d.branch;
    mem_write_d   = (state_d == S_MEM) & ctrl_d.store;
    reg_write_d   = wb_s ? ctrl_d.reg_write  : 2'd0;
    mem_to_reg_d  = wb_s ? ctrl_d.mem_to_reg : 2'd0;
    // Every WB is a retire; EXEC retires only instructions with nothing after it.
    pc_write_d    = wb_s | (exec_s & retires_in_exec(ctrl_d));
  end

  // State, latches and registered outputs
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_FETCH;
      instr_q       <= {IW{1'b0}};
      ctrl_q        <= CTRL_NOP;
      instr_ready_q <= 1'b1;
      format_q      <= 1'b0;
      acc_read_q    <= 1'b0;
      branch_q      <= 1'b0;
      mem_write_q   <= 1'b0;
      pc_write_q    <= 1'b0;
      halt_q        <= 1'b0;
      reg_write_q   <= 2'd0;
      alu_src_b_q   <= 2'd0;
      mem_to_reg_q  <= 2'd0;
      alu_op_q      <= 4'd0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      ctrl_q        <= ctrl_d;
      instr_ready_q <= instr_ready_d;
      format_q      <= format_d;
      acc_read_q    <= acc_read_d;
      branch_q      <= branch_d;
      mem_write_q   <= mem_write_d;
      pc_write_q    <= pc_write_d;
      halt_q        <= halt_d;
      reg_write_q   <= reg_write_d;
      alu_src_b_q   <= alu_src_b_d;
      mem_to_reg_q  <= mem_to_reg_d;
      alu_op_q      <= alu_op_d;
    end
  end

  assign store_retire_s = (state_q == S_MEM) & ctrl_q.store & mem_ready;
  assign pc_write_s     = pc_write_q | store_retire_s;

  assign instr_ready = instr_ready_q & reset_n;
  assign Format      = format_q;
  assign AccRead     = acc_read_q;
  assign Branch      = branch_q;
  assign MemWrite    = mem_write_q;
  assign PCWrite     = pc_write_s;
  assign RegWrite    = reg_write_q;
  assign ALUSrcB     = alu_src_b_q;
  assign MemtoReg    = mem_to_reg_q;
  assign ALUOp       = alu_op_q;
  assign HALT        = halt_q;
  assign state       = state_q;

`ifdef MC_PERF_CNT_EN
  logic [31:0] retire_cnt_q, retire_cnt_d, stall_cnt_q, stall_cnt_d;

  // Counter increments; both wrap naturally at 2^32
  always_comb begin
    retire_cnt_d = pc_write_s ? (retire_cnt_q + 32'd1) : retire_cnt_q;
    stall_cnt_d  = ((state_q == S_MEM) && !mem_ready) ? (stall_cnt_q + 32'd1) : stall_cnt_q;
  end

  // Performance counter registers
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      retire_cnt_q <= 32'd0;
      stall_cnt_q  <= 32'd0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign retire_cnt = retire_cnt_q;
  assign stall_cnt  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control (default IW=9, OPW=4).
// Instruction words are {opcode, 5-bit operand}. Outputs are sampled 1-2 time
// units after the rising edge; inputs are driven at the same point.
module tb_multicycle_control;

  logic       CLK = 1'b0;
  logic       reset_n;
  logic       instr_valid;
  logic [8:0] Instruction;
  logic       instr_ready;
  logic       mem_ready;
  logic       resume;
  logic       Format, AccRead, Branch, MemWrite, PCWrite, HALT;
  logic [1:0] RegWrite, ALUSrcB, MemtoReg;
  logic [3:0] ALUOp;
  logic [2:0] state;
`ifdef MC_PERF_CNT_EN
  logic [31:0] retire_cnt, stall_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Results collected by run_instr
  int          r_lat, r_memw, r_pcw, r_regw, r_mtr, r_br, r_bad;
  logic [31:0] r_trace;
  logic [8:0]  r_exec;

  multicycle_control dut (
    .CLK         (CLK),
    .reset_n     (reset_n),
    .instr_valid (instr_valid),
    .Instruction (Instruction),
    .instr_ready (instr_ready),
    .mem_ready   (mem_ready),
    .resume      (resume),
    .Format      (Format),
    .AccRead     (AccRead),
    .Branch      (Branch),
    .MemWrite    (MemWrite),
    .PCWrite     (PCWrite),
    .RegWrite    (RegWrite),
    .ALUSrcB     (ALUSrcB),
    .MemtoReg    (MemtoReg),
    .ALUOp       (ALUOp),
    .HALT        (HALT),
    .state       (state)
`ifdef MC_PERF_CNT_EN
    ,
    .retire_cnt  (retire_cnt),
    .stall_cnt   (stall_cnt)
`endif
  );

  // Free-running clock
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Issue one instruction from FETCH and follow it until instr_ready returns.
  // mem_ready is held low for the first stall_n MEM cycles, and is driven to
  // mr_out in every other state.
  task automatic run_instr(input logic [3:0] op, input int stall_n, input logic mr_out);
    int mem_seen;
    mem_seen = 0;
    r_lat = -1; r_memw = 0; r_pcw = 0; r_regw = 0; r_mtr = 0; r_br = 0; r_bad = 0;
    r_trace = 32'd0; r_exec = 9'd0;
    mem_ready   = mr_out;
    Instruction = {op, 5'b10101};
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      r_trace = {r_trace[28:0], state};
      if (state == 3'd3) begin
        mem_ready = (mem_seen >= stall_n);
        mem_seen++;
      end else begin
        mem_ready = mr_out;
      end
      #1;
      if (MemWrite) r_memw++;
      if (PCWrite) r_pcw++;
      if (RegWrite != 2'd0) r_regw++;
      if (MemtoReg != 2'd0) r_mtr++;
      if (Branch) r_br++;
      if (state == 3'd2) r_exec = {ALUOp, ALUSrcB, Format, AccRead, Branch};
      if ((Branch && state != 3'd2) || (MemWrite && state != 3'd3) ||
          (RegWrite != 2'd0 && state != 3'd4) || (MemtoReg != 2'd0 && state != 3'd4) ||
          (instr_ready && state != 3'd0)) r_bad++;
      if (state == 3'd0) begin
        r_lat = c;
        break;
      end
      tick();
    end
    mem_ready = mr_out;
  endtask

  initial begin
    reset_n = 1'b0; instr_valid = 1'b0; Instruction = 9'd0; mem_ready = 1'b0; resume = 1'b0;

    // Reset state
    #12;
    check_eq("rst_state",       32'(state), 32'd0);
    check_eq("rst_ready_low",   32'(instr_ready), 32'd0);
    check_eq("rst_halt",        32'(HALT), 32'd0);
    check_eq("rst_pcwrite",     32'(PCWrite), 32'd0);
    @(negedge CLK);
    reset_n = 1'b1;
    #1;
    check_eq("rel_ready",       32'(instr_ready), 32'd1);
    check_eq("rel_state",       32'(state), 32'd0);
    tick();

    // ADD: FETCH DECODE EXEC WB FETCH, mem_ready held high outside MEM
    run_instr(4'h0, 0, 1'b1);
    check_eq("add_trace",   r_trace, 32'({3'd1, 3'd2, 3'd4, 3'd0}));
    check_eq("add_latency", 32'(r_lat), 32'd4);
    check_eq("add_pcw",     32'(r_pcw), 32'd1);
    check_eq("add_regw",    32'(r_regw), 32'd1);
    check_eq("add_exec",    32'(r_exec), 32'({4'd0, 2'd0, 1'b0, 1'b0, 1'b0}));
    check_eq("add_strobes", 32'(r_bad), 32'd0);

    // ST with three stall cycles
    run_instr(4'h9, 3, 1'b1);
    check_eq("st_trace",    r_trace, 32'({3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd0}));
    check_eq("st_memwrite", 32'(r_memw), 32'd4);
    check_eq("st_latency",  32'(r_lat), 32'd7);
    check_eq("st_pcw",      32'(r_pcw), 32'd1);
    check_eq("st_regw",     32'(r_regw), 32'd0);
    check_eq("st_exec",     32'(r_exec), 32'({4'd0, 2'd1, 1'b1, 1'b1, 1'b0}));
    check_eq("st_strobes",  32'(r_bad), 32'd0);
`ifdef MC_PERF_CNT_EN
    check_eq("st_stall_cnt",  stall_cnt, 32'd3);
    check_eq("st_retire_cnt", retire_cnt, 32'd2);
`endif

    // LD with memory ready at once
    run_instr(4'h8, 0, 1'b0);
    check_eq("ld_trace",    r_trace, 32'({3'd1, 3'd2, 3'd3, 3'd4, 3'd0}));
    check_eq("ld_latency",  32'(r_lat), 32'd5);
    check_eq("ld_memtoreg", 32'(r_mtr), 32'd1);
    check_eq("ld_pcw",      32'(r_pcw), 32'd1);
    check_eq("ld_memwrite", 32'(r_memw), 32'd0);
    check_eq("ld_strobes",  32'(r_bad), 32'd0);

    // SUB, ADDI, BEQ: control word contents
    run_instr(4'h1, 0, 1'b0);
    check_eq("sub_exec",    32'(r_exec), 32'({4'd1, 2'd0, 1'b0, 1'b0, 1'b0}));
    check_eq("sub_latency", 32'(r_lat), 32'd4);
    run_instr(4'h7, 0, 1'b0);
    check_eq("addi_exec",   32'(r_exec), 32'({4'd0, 2'd1, 1'b1, 1'b0, 1'b0}));
    run_instr(4'hA, 0, 1'b1);
    check_eq("beq_trace",   r_trace, 32'({3'd1, 3'd2, 3'd0}));
    check_eq("beq_latency", 32'(r_lat), 32'd3);
    check_eq("beq_branch",  32'(r_br), 32'd1);
    check_eq("beq_pcw",     32'(r_pcw), 32'd1);
    check_eq("beq_exec",    32'(r_exec), 32'({4'd1, 2'd0, 1'b1, 1'b1, 1'b1}));
    check_eq("beq_strobes", 32'(r_bad), 32'd0);

    // HALT: enter, ignore instr_valid, leave on resume
    Instruction = {4'hF, 5'd0};
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    check_eq("halt_decode_state", 32'(state), 32'd1);
    check_eq("halt_decode_halt",  32'(HALT), 32'd0);
    tick();
    check_eq("halt_state",   32'(state), 32'd5);
    check_eq("halt_flag",    32'(HALT), 32'd1);
    check_eq("halt_pcwrite", 32'(PCWrite), 32'd0);
    instr_valid = 1'b1;
    tick();
    tick();
    instr_valid = 1'b0;
    check_eq("halt_ignore_state", 32'(state), 32'd5);
    check_eq("halt_ignore_ready", 32'(instr_ready), 32'd0);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    check_eq("resume_state", 32'(state), 32'd0);
    check_eq("resume_halt",  32'(HALT), 32'd0);
    check_eq("resume_ready", 32'(instr_ready), 32'd1);

    // Asynchronous reset while a store waits in MEM
    mem_ready   = 1'b0;
    Instruction = {4'h9, 5'd0};
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    tick();
    check_eq("mem_state",    32'(state), 32'd3);
    check_eq("mem_memwrite", 32'(MemWrite), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("arst_state",    32'(state), 32'd0);
    check_eq("arst_memwrite", 32'(MemWrite), 32'd0);
    check_eq("arst_ready",    32'(instr_ready), 32'd0);
    check_eq("arst_outs",     32'({Format, AccRead, Branch, PCWrite, HALT, RegWrite, ALUSrcB, MemtoReg, ALUOp}), 32'd0);
    #2;
    reset_n = 1'b1;
    #1;
    check_eq("arst_rel_state", 32'(state), 32'd0);
    check_eq("arst_rel_ready", 32'(instr_ready), 32'd1);
    tick();

`ifdef MC_PERF_CNT_EN
    check_eq("arst_retire_cnt", retire_cnt, 32'd0);
    for (int i = 0; i < 10; i++) begin
      run_instr(4'h0, 0, 1'b0);
    end
    check_eq("ten_retire_cnt", retire_cnt, 32'd10);
    check_eq("ten_stall_cnt",  stall_cnt, 32'd0);
    force dut.retire_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_cnt_q;
    run_instr(4'h0, 0, 1'b0);
    check_eq("wrap_retire_cnt", retire_cnt, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
